// File: rtl/mipspkg.sv
// Shared definitions for the data-memory arbiter.
//   arb_state_t : arbiter FSM state encoding
//   REQ_CORE / REQ_DBG : requester indices into the req/gnt/rvalid vectors
package mipspkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_t;

  localparam int NUM_REQ  = 2;
  localparam int REQ_CORE = 0;
  localparam int REQ_DBG  = 1;
  localparam int CNT_W    = 16;

endpackage

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port data RAM.
// Requester 0 is the core, requester 1 the debug loader.
//   clk, reset        : clock, async active-low reset
//   req/we/addr/wdata : per-requester request, held until gnt
//   gnt               : one-cycle pulse in the cycle the RAM access is issued
//   rvalid/rdata      : one-cycle read return, the cycle after gnt
//   ram_*             : single-port RAM interface (read data one cycle late)
//   conflict_cnt      : saturating count of IDLE cycles with both requesting
module dmem_arbiter
  import mipspkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ-1:0]              we,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0]  addr,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]  wdata,
  output logic [NUM_REQ-1:0]              gnt,
  output logic [NUM_REQ-1:0]              rvalid,
  output logic [DATA_W-1:0]               rdata,
  output logic                            ram_en,
  output logic                            ram_we,
  output logic [ADDR_W-1:0]               ram_addr,
  output logic [DATA_W-1:0]               ram_wdata,
  input  logic [DATA_W-1:0]               ram_rdata,
  output logic [CNT_W-1:0]                conflict_cnt
);

  arb_state_t        state_q, state_d;
  logic              last_q, last_d;   // 1 = debug granted last
  logic              win_q, win_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // On a tie the requester not granted last wins; otherwise the sole one.
  function automatic logic rr_pick(input logic [NUM_REQ-1:0] r, input logic last);
    if (&r) return ~last;
    return r[REQ_DBG];
  endfunction

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    win_d   = win_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    gnt     = '0;
    rvalid  = '0;
    rdata   = '0;
    ram_en  = 1'b0;
    ram_we  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          win_d   = rr_pick(req, last_q);
          we_d    = we[win_d];
          addr_d  = addr[win_d];
          wdata_d = wdata[win_d];
          state_d = ST_ACCESS;
        end
        if (&req && cnt_q != '1) cnt_d = cnt_q + 16'd1;
      end
      ST_ACCESS: begin
        ram_en     = 1'b1;
        ram_we     = we_q;
        gnt[win_q] = 1'b1;
        last_d     = win_q;
        state_d    = we_q ? ST_IDLE : ST_RESP;
      end
      ST_RESP: begin
        rvalid[win_q] = 1'b1;
        rdata         = ram_rdata;
        state_d       = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;   // debug "last", so the core wins the first tie
      win_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      win_q   <= win_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
    end
  end

  // Captured request registers only change at arbitration, so they already
  // hold their last value outside ACCESS.
  assign ram_addr     = addr_q;
  assign ram_wdata    = wdata_q;
  assign conflict_cnt = cnt_q;

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8, word-address width of the shared data RAM.
REQ-002 Parameter DATA_W, default 32, data word width.
REQ-003 clk  input  1  single clock for the block; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-005 req  input  2  access request per requester; index 0 = core, index 1 = debug loader.
REQ-006 we  input  2  per-requester write enable (1 = write, 0 = read).
REQ-007 addr  input  2 x ADDR_W  per-requester word address.
REQ-008 wdata  input  2 x DATA_W  per-requester write data.
REQ-009 gnt  output  2  one-hot grant pulse, one cycle, marks the cycle the RAM access is issued.
REQ-010 rvalid  output  2  one-hot read-data-valid pulse, one cycle.
REQ-011 rdata  output  DATA_W  read data, meaningful only while some rvalid bit is 1.
REQ-012 ram_en  output  1  RAM access strobe.
REQ-013 ram_we  output  1  RAM write strobe, qualified by ram_en.
REQ-014 ram_addr  output  ADDR_W  RAM address.
REQ-015 ram_wdata  output  DATA_W  RAM write data.
REQ-016 ram_rdata  input  DATA_W  RAM read data, valid the cycle after ram_en with ram_we=0.
REQ-017 conflict_cnt  output  16  count of cycles where both requests were high in IDLE.

Function
REQ-018 FSM states IDLE, ACCESS, RESP; IDLE arbitrates, ACCESS drives RAM, RESP returns read data.
REQ-019 IDLE with any req=1: register winner's we/addr/wdata, next state ACCESS.
REQ-020 Single requester wins unconditionally; both requesting: winner = requester not granted last (round-robin).
REQ-021 last-grant register updates on every grant; reset value selects core as first winner on a tie.
REQ-022 ACCESS: ram_en=1, ram_we/ram_addr/ram_wdata from registered request, gnt[winner]=1 for exactly this cycle.
REQ-023 ACCESS with write: next state IDLE; no rvalid.
REQ-024 ACCESS with read: next state RESP; RESP drives rvalid[winner]=1, rdata=ram_rdata, next state IDLE.
REQ-025 Latency: read = 2 cycles from IDLE-detect to gnt+1... i.e. gnt at cycle N+1, rvalid at N+2 for request seen at N; write occupancy 2 cycles, read occupancy 3 cycles.
REQ-026 Requester holds req, we, addr, wdata stable until its gnt; deasserts req in the cycle after gnt or issues a new request.
REQ-027 req sampled only in IDLE; req dropped before being sampled is ignored with no side effect.
REQ-028 Outside ACCESS: ram_en=0, ram_we=0; ram_addr/ram_wdata hold last value.
REQ-029 conflict_cnt increments by 1 per IDLE cycle with req=2'b11; saturates at 16'hFFFF.
REQ-030 gnt and rvalid never have more than one bit set; never both set in the same cycle.

Reset
REQ-031 reset=0 forces immediately: state IDLE, gnt=0, rvalid=0, ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0, conflict_cnt=0, last-grant=debug.
REQ-032 Reset in ACCESS or RESP abandons the access: no gnt or rvalid after reset release for it; requester must re-request.
REQ-033 First arbitration takes place on the first rising edge with reset=1.

Structure
REQ-034 mipspkg holds the FSM state enum (arb_state_t) and requester index constants (REQ_CORE=0, REQ_DBG=1).
REQ-035 Single module, no sub-modules; round-robin pick is an in-module function.

Verification
REQ-036 Core read only, addr=8'h12, RAM holds 32'hDEADBEEF -> gnt=2'b01 next cycle, rvalid=2'b01 with rdata=32'hDEADBEEF one cycle later.
REQ-037 Debug write addr=8'h05, wdata=32'h00001234 -> ACCESS cycle ram_en=1, ram_we=1, ram_addr=8'h05; gnt=2'b10; no rvalid; back to IDLE.
REQ-038 Both requesting continuously for 4 grants after reset -> grant order core, debug, core, debug; conflict_cnt=4.
REQ-039 Reset asserted in RESP of a core read -> rvalid stays 0, all outputs zero, conflict_cnt=0; next request after release served normally.
REQ-040 Force conflict_cnt near 16'hFFFF, continue contention -> holds at 16'hFFFF, no wrap to 0.
